// File: rtl/param_register_file.sv
// WIDTH x DEPTH register file: two combinational read ports, one synchronous write
// port, and a sequenced bulk-clear engine. Define RF_BYPASS_EN for write-to-read forwarding.
module param_register_file #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    rd_addr1,
  input  logic [AW-1:0]    rd_addr2,
  output logic [WIDTH-1:0] rd_data1,
  output logic [WIDTH-1:0] rd_data2,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clr_req,
  output logic             clr_busy,
  output logic             clr_done
);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } state_e;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_e           state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];

  logic wr_in_range, rd1_in_range, rd2_in_range;
  logic wr_accept;

  // Addresses past DEPTH only exist when DEPTH is not a power of two.
  if (DEPTH == (1 << AW)) begin : g_full_range
    assign wr_in_range  = 1'b1;
    assign rd1_in_range = 1'b1;
    assign rd2_in_range = 1'b1;
  end else begin : g_partial_range
    assign wr_in_range  = (wr_addr  < AW'(DEPTH));
    assign rd1_in_range = (rd_addr1 < AW'(DEPTH));
    assign rd2_in_range = (rd_addr2 < AW'(DEPTH));
  end

  assign wr_accept = wr_en && (state_q != CLEAR) && wr_in_range;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    regs_d   = regs_q;
    clr_busy = 1'b0;
    clr_done = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        clr_busy      = 1'b1;
        regs_d[ptr_q] = '0;
        if (ptr_q == LAST_IDX) begin
          state_d = DONE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      DONE: begin
        clr_done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A user write never collides with the clear walk: wr_accept is low in CLEAR.
    if (wr_accept) regs_d[wr_addr] = wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments only. The storage array is
  // reset as well, because an asynchronous reset must leave every register reading 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
    end
  end

  always_comb begin
    rd_data1 = '0;
    rd_data2 = '0;
    if (rd1_in_range) rd_data1 = regs_q[rd_addr1];
    if (rd2_in_range) rd_data2 = regs_q[rd_addr2];
`ifdef RF_BYPASS_EN
    if (wr_accept && (wr_addr == rd_addr1)) rd_data1 = wr_data;
    if (wr_accept && (wr_addr == rd_addr2)) rd_data2 = wr_data;
`endif
  end

endmodule

// File: tb/tb_param_register_file.sv
// Directed bench for param_register_file: a 16x4 instance and an 8x5 instance
// (non-power-of-two depth), table-driven read/write vectors plus clear-engine sequences.
module tb_param_register_file;

  logic clk;
  logic rst;

  logic [1:0]  a_rd_addr1, a_rd_addr2, a_wr_addr;
  logic [15:0] a_rd_data1, a_rd_data2, a_wr_data;
  logic        a_wr_en, a_clr_req, a_clr_busy, a_clr_done;

  logic [2:0]  b_rd_addr1, b_rd_addr2, b_wr_addr;
  logic [7:0]  b_rd_data1, b_rd_data2, b_wr_data;
  logic        b_wr_en, b_clr_req, b_clr_busy, b_clr_done;

  int passed = 0;
  int total  = 0;

  param_register_file #(.WIDTH(16), .DEPTH(4)) dut_a (
    .clk(clk), .rst(rst),
    .rd_addr1(a_rd_addr1), .rd_addr2(a_rd_addr2),
    .rd_data1(a_rd_data1), .rd_data2(a_rd_data2),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .clr_req(a_clr_req), .clr_busy(a_clr_busy), .clr_done(a_clr_done)
  );

  param_register_file #(.WIDTH(8), .DEPTH(5)) dut_b (
    .clk(clk), .rst(rst),
    .rd_addr1(b_rd_addr1), .rd_addr2(b_rd_addr2),
    .rd_data1(b_rd_data1), .rd_data2(b_rd_data2),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .clr_req(b_clr_req), .clr_busy(b_clr_busy), .clr_done(b_clr_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  ra1;
    logic [1:0]  ra2;
    logic [15:0] e1;
    logic [15:0] e2;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    int done_at;
    logic [15:0] exp_byp;

    // Reads are checked before the edge, so each row sees the earlier rows' writes only.
    vecs[0] = '{1'b1, 2'd2, 16'hA5A5, 2'd0, 2'd1, 16'h0000, 16'h0000};
    vecs[1] = '{1'b1, 2'd3, 16'h1234, 2'd2, 2'd2, 16'hA5A5, 16'hA5A5};
    vecs[2] = '{1'b0, 2'd0, 16'hDEAD, 2'd2, 2'd3, 16'hA5A5, 16'h1234};
    vecs[3] = '{1'b1, 2'd0, 16'h0001, 2'd3, 2'd3, 16'h1234, 16'h1234};
    vecs[4] = '{1'b1, 2'd1, 16'h00FF, 2'd0, 2'd2, 16'h0001, 16'hA5A5};
    vecs[5] = '{1'b0, 2'd1, 16'hDEAD, 2'd1, 2'd0, 16'h00FF, 16'h0001};

    a_rd_addr1 = '0; a_rd_addr2 = '0; a_wr_addr = '0; a_wr_data = '0;
    a_wr_en = 1'b0; a_clr_req = 1'b0;
    b_rd_addr1 = '0; b_rd_addr2 = '0; b_wr_addr = '0; b_wr_data = '0;
    b_wr_en = 1'b0; b_clr_req = 1'b0;

    // Reset applied with no clock edge involved.
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("reset_busy", 32'(a_clr_busy), 32'd0);
    check("reset_done", 32'(a_clr_done), 32'd0);
    for (int i = 0; i < 4; i++) begin
      a_rd_addr1 = 2'(i);
      a_rd_addr2 = 2'(3 - i);
      #1;
      check($sformatf("reset_rd1_r%0d", i), 32'(a_rd_data1), 32'd0);
      check($sformatf("reset_rd2_r%0d", 3 - i), 32'(a_rd_data2), 32'd0);
    end
    #3 rst = 1'b0;
    tick();

    // Table-driven writes and dual-port reads.
    for (int v = 0; v < 6; v++) begin
      a_wr_en    = vecs[v].wr_en;
      a_wr_addr  = vecs[v].wr_addr;
      a_wr_data  = vecs[v].wr_data;
      a_rd_addr1 = vecs[v].ra1;
      a_rd_addr2 = vecs[v].ra2;
      #1;
      check($sformatf("vec%0d_rd1", v), 32'(a_rd_data1), 32'(vecs[v].e1));
      check($sformatf("vec%0d_rd2", v), 32'(a_rd_data2), 32'(vecs[v].e2));
      tick();
    end
    a_wr_en = 1'b0;

    // Fill with FFFF, clear; a write to r1 held through busy must be dropped.
    for (int i = 0; i < 4; i++) begin
      a_wr_en = 1'b1; a_wr_addr = 2'(i); a_wr_data = 16'hFFFF;
      tick();
    end
    a_wr_en = 1'b0;
    a_rd_addr1 = 2'd0;
    a_rd_addr2 = 2'd1;
    a_clr_req = 1'b1;
    tick();
    a_clr_req = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      a_wr_en = (k <= 4); a_wr_addr = 2'd1; a_wr_data = 16'h7777;
      #1;
      check($sformatf("clr_busy_c%0d", k), 32'(a_clr_busy), 32'(k <= 4));
      check($sformatf("clr_done_c%0d", k), 32'(a_clr_done), 32'(k == 5));
      if (k == 1) begin
        check("clr_c1_r0_old", 32'(a_rd_data1), 32'h0000FFFF);
        check("clr_c1_r1_old", 32'(a_rd_data2), 32'h0000FFFF);
      end
      if (k == 2) begin
        check("clr_c2_r0_cleared", 32'(a_rd_data1), 32'd0);
        check("clr_c2_r1_old", 32'(a_rd_data2), 32'h0000FFFF);
      end
      tick();
    end
    a_wr_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_rd_addr1 = 2'(i);
      #1;
      check($sformatf("after_clr_r%0d", i), 32'(a_rd_data1), 32'd0);
    end

    // Write and clear request on the same IDLE edge: write lands, then gets cleared.
    a_wr_en = 1'b1; a_wr_addr = 2'd2; a_wr_data = 16'h1111; a_clr_req = 1'b1;
    tick();
    a_wr_en = 1'b0; a_clr_req = 1'b0;
    a_rd_addr1 = 2'd2;
    #1;
    check("simul_write_landed", 32'(a_rd_data1), 32'h00001111);
    check("simul_busy", 32'(a_clr_busy), 32'd1);
    done_at = 0;
    for (int k = 1; k <= 10; k++) begin
      if (a_clr_done && done_at == 0) done_at = k;
      tick();
    end
    check("simul_done_cycle", 32'(done_at), 32'd5);
    check("simul_write_cleared", 32'(a_rd_data1), 32'd0);

    // Reset in the second CLEAR cycle aborts the clear with no done pulse.
    a_wr_en = 1'b1; a_wr_addr = 2'd1; a_wr_data = 16'h5555;
    tick();
    a_wr_addr = 2'd3; a_wr_data = 16'h3333;
    tick();
    a_wr_en = 1'b0;
    a_clr_req = 1'b1;
    tick();
    a_clr_req = 1'b0;
    tick();
    a_rd_addr1 = 2'd1;
    a_rd_addr2 = 2'd3;
    #1;
    check("rstclr_r1_before", 32'(a_rd_data1), 32'h00005555);
    check("rstclr_busy_before", 32'(a_clr_busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rstclr_r1_async", 32'(a_rd_data1), 32'd0);
    check("rstclr_r3_async", 32'(a_rd_data2), 32'd0);
    check("rstclr_busy_async", 32'(a_clr_busy), 32'd0);
    check("rstclr_done_async", 32'(a_clr_done), 32'd0);
    #1 rst = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (a_clr_busy) busy_cnt++;
      if (a_clr_done) done_cnt++;
    end
    check("rstclr_no_busy", 32'(busy_cnt), 32'd0);
    check("rstclr_no_done", 32'(done_cnt), 32'd0);
    a_wr_en = 1'b1; a_wr_addr = 2'd1; a_wr_data = 16'h0042;
    tick();
    a_wr_en = 1'b0;
    #1;
    check("post_rst_write", 32'(a_rd_data1), 32'h00000042);

    // Same-cycle write and read of r1: forwarded only when bypass is built in.
`ifdef RF_BYPASS_EN
    exp_byp = 16'hBEEF;
`else
    exp_byp = 16'h0042;
`endif
    a_rd_addr1 = 2'd1;
    a_wr_en = 1'b1; a_wr_addr = 2'd1; a_wr_data = 16'hBEEF;
    #1;
    check("bypass_same_cycle", 32'(a_rd_data1), 32'(exp_byp));
    tick();
    a_wr_en = 1'b0;
    #1;
    check("bypass_after_edge", 32'(a_rd_data1), 32'h0000BEEF);

    // DEPTH=5, WIDTH=8: out-of-range write dropped, out-of-range reads return 0.
    b_wr_en = 1'b1; b_wr_addr = 3'd6; b_wr_data = 8'hAB;
    tick();
    b_wr_addr = 3'd4; b_wr_data = 8'h5A;
    tick();
    b_wr_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b_rd_addr1 = 3'(i);
      #1;
      check($sformatf("b_r%0d", i), 32'(b_rd_data1), (i == 4) ? 32'h5A : 32'd0);
    end
    b_rd_addr2 = 3'd7;
    #1;
    check("b_read_addr7", 32'(b_rd_data2), 32'd0);
    b_rd_addr2 = 3'd6;
    #1;
    check("b_read_addr6", 32'(b_rd_data2), 32'd0);

    b_clr_req = 1'b1;
    tick();
    b_clr_req = 1'b0;
    busy_cnt = 0;
    done_at  = 0;
    for (int k = 1; k <= 10; k++) begin
      if (b_clr_busy) busy_cnt++;
      if (b_clr_done && done_at == 0) done_at = k;
      tick();
    end
    check("b_clr_busy_cycles", 32'(busy_cnt), 32'd5);
    check("b_clr_done_cycle", 32'(done_at), 32'd6);
    b_rd_addr1 = 3'd4;
    #1;
    check("b_r4_cleared", 32'(b_rd_data1), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
